tt_um_serial_add_ctrl: RTL
==========================

TT_UM_SERIAL_ADD_CTRL -- requirements
Module: tt_um_serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (fixed to 8 by pinout).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 ena  input  1  design enable; low = stall, all state held.
REQ-005 ui_in  input  8  operand byte for load strobes.
REQ-006 uio_in  input  8  [0] load_a, [1] load_b, [2] start, [3] ack; [7:4] unused.
REQ-007 uo_out  output  8  result register (sum bits).
REQ-008 uio_out  output  8  [3:0]=0, [4] busy, [5] done, [6] carry_out, [7] 0.
REQ-009 uio_oe  output  8  constant 8'b1111_0000.

Function
REQ-010 The block SHALL sequence one 1-bit full-adder datapath bit-serially over WIDTH cycles to add registers A and B.
REQ-011 FSM states SHALL be IDLE, RUN, DONE; all transitions and captures occur only on edges where ena=1.
REQ-012 IDLE: load_a=1 captures ui_in into A; load_b=1 captures ui_in into B; both may fire in one cycle (same byte to both).
REQ-013 IDLE: start=1 with load_a=load_b=0 SHALL be accepted: result<=0, carry<=0, bit counter<=0, state<=RUN.
REQ-014 IDLE: start=1 in the same cycle as any load SHALL be ignored (loads still captured).
REQ-015 RUN: each enabled cycle SHALL compute s=A[0]^B[0]^c, c'=maj(A[0],B[0],c), shift A and B right by one, shift s into result MSB (result right-shift), counter+1.
REQ-016 RUN SHALL last exactly WIDTH enabled cycles; on the edge completing bit WIDTH-1 state<=DONE, carry_out<=final carry.
REQ-017 Latency: done SHALL be visible exactly 8 enabled cycles after the edge that accepted start.
REQ-018 busy=1 iff state=RUN; done=1 iff state=DONE.
REQ-019 DONE: result and carry_out held; ack=1 SHALL return state to IDLE next edge; result/carry_out remain valid until next accepted start.
REQ-020 Loads and start during RUN or DONE SHALL be ignored; ack outside DONE ignored.
REQ-021 DONE with ack and start both high: return to IDLE, start ignored.
REQ-022 Arithmetic is unsigned modulo 2^8; carry_out is bit 8 of the true sum.
REQ-023 ena=0 mid-RUN SHALL freeze counter, shift registers and carry; latency extends by the stalled cycles.
REQ-024 uio_in[7:4] SHALL have no effect.

Reset
REQ-025 On an rst_n=0 edge (regardless of ena) state<=IDLE; A, B, result, counter, carry, carry_out<=0.
REQ-026 Reset values: uo_out=0x00, uio_out=0x00, uio_oe=0xF0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation with no partial result retained.

Structure
REQ-028 Shared package tt_sadd_pkg SHALL hold WIDTH, the state encoding (IDLE=0, RUN=1, DONE=2), and uio bit-index constants for load_a, load_b, start, ack, busy, done, carry_out.
REQ-029 The full adder SHALL be built from two instances of sub-module ha_cell (a, b -> sum, carry) plus an OR of the two carries.
REQ-030 Counter SHALL be 3 bits (log2 WIDTH); completion detected at count 7.

Verification
REQ-031 Load A=0x35, B=0x4A, start -> after 8 cycles done=1, uo_out=0x7F, carry_out=0.
REQ-032 A=0xFF, B=0x01, start -> uo_out=0x00, carry_out=1; A=0xFF, B=0xFF -> uo_out=0xFE, carry_out=1.
REQ-033 start with load_a in same cycle -> busy stays 0; re-assert start alone -> normal run.
REQ-034 start/load_a pulsed during RUN -> no effect; result of original operands unchanged.
REQ-035 ena low for 3 cycles mid-RUN -> done appears at 11 cycles after start, correct sum.
REQ-036 rst_n low at RUN cycle 4 -> next edge busy=0, uo_out=0x00, carry_out=0; fresh run then correct.

Source files
------------

// File: rtl/tt_sadd_pkg.sv
// rtl/tt_sadd_pkg.sv - shared width, state encoding and uio bit map for the serial adder
package tt_sadd_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // uio_in control strobes
  localparam int LOAD_A_BIT    = 0;
  localparam int LOAD_B_BIT    = 1;
  localparam int START_BIT     = 2;
  localparam int ACK_BIT       = 3;

  // uio_out status flags
  localparam int BUSY_BIT      = 4;
  localparam int DONE_BIT      = 5;
  localparam int CARRY_OUT_BIT = 6;

endpackage

// File: rtl/ha_cell.sv
// rtl/ha_cell.sv - half adder; two of these plus an OR form the serial full adder
module ha_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/tt_um_serial_add_ctrl.sv
// rtl/tt_um_serial_add_ctrl.sv - bit-serial unsigned adder with load/start/ack handshake
module tt_um_serial_add_ctrl #(
  parameter int WIDTH = tt_sadd_pkg::WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  import tt_sadd_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;

  logic load_a, load_b, start, ack;
  logic s0, c0, fa_sum, c1, fa_carry;
  logic unused_uio_bits;

  assign load_a = uio_in[LOAD_A_BIT];
  assign load_b = uio_in[LOAD_B_BIT];
  assign start  = uio_in[START_BIT];
  assign ack    = uio_in[ACK_BIT];
  assign unused_uio_bits = ^uio_in[7:4];

  // Full adder on the LSBs of the shift registers and the running carry
  ha_cell u_ha_ab (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .sum   (s0),
    .carry (c0)
  );

  ha_cell u_ha_c (
    .a     (s0),
    .b     (carry_q),
    .sum   (fa_sum),
    .carry (c1)
  );

  assign fa_carry = c0 | c1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE: begin
        if (load_a) a_d = ui_in[WIDTH-1:0];
        if (load_b) b_d = ui_in[WIDTH-1:0];
        // A start coinciding with a load is dropped so operands are never half-updated
        if (start && !load_a && !load_b) begin
          result_d = '0;
          carry_d  = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        result_d = {fa_sum, result_q[WIDTH-1:1]};
        carry_d  = fa_carry;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    uio_out                = '0;
    uio_out[BUSY_BIT]      = (state_q == RUN);
    uio_out[DONE_BIT]      = (state_q == DONE);
    uio_out[CARRY_OUT_BIT] = cout_q;
  end

  assign uo_out = result_q;
  assign uio_oe = 8'b1111_0000;

endmodule
